// File: rtl/tt_pkg.sv
// Shared encodings for the marble launcher: colours, halt codes and FSM states.
package tt_pkg;

  localparam logic BLUE = 1'b0;
  localparam logic RED  = 1'b1;

  localparam logic [1:0] HALT_NONE      = 2'b00;
  localparam logic [1:0] HALT_INTERCEPT = 2'b01;
  localparam logic [1:0] HALT_EMPTY     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/marble_stock.sv
// Per-colour marble stock: reloads to INIT, decrements on release, never wraps below zero.
module marble_stock #(
  parameter int INIT  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

  logic [CNT_W-1:0] count_q, count_d;

  // A reload and a release can land on the same edge when go launches the first marble.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = (dec && (INIT_V != '0)) ? INIT_V - 1'b1 : INIT_V;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= INIT_V;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/marble_launcher.sv
// Marble release sequencer: releases marbles on go and on lever hits, logs lever sides.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | waiting for go after reset
//  S_RELEASE | one-cycle start pulse, stock of selected colour decremented
//  S_RUN     | marble on the board; waiting for a lever hit or a stop
//  S_SETTLE  | down-counting before releasing the next marble
//  S_DONE    | run finished, halt_reason holds why; waits for go
module marble_launcher
  import tt_pkg::*;
#(
  parameter int BLUE_COUNT = 8,
  parameter int RED_COUNT  = 8,
  parameter int CNT_W      = 4,
  parameter int SETTLE     = 2,
  parameter int LOG_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           go,
  input  logic                           go_colour,
  input  logic                           lever_hit,
  input  logic                           lever_side,
  input  logic                           stopped,
  output logic                           start,
  output logic                           marble_colour,
  output logic [CNT_W-1:0]               blue_left,
  output logic [CNT_W-1:0]               red_left,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     halt_reason,
  output logic [LOG_DEPTH-1:0]           log,
  output logic [$clog2(LOG_DEPTH+1)-1:0] log_len
);

  localparam int LEN_W = $clog2(LOG_DEPTH + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;
  localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(LOG_DEPTH);

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 start_q, start_d;
  logic                 colour_q, colour_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           halt_q, halt_d;
  logic [LOG_DEPTH-1:0] log_q, log_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [SET_W-1:0]     settle_q, settle_d;

  logic reload, rel, dec_blue, dec_red;
  logic blue_empty, red_empty;

  marble_stock #(.INIT(BLUE_COUNT), .CNT_W(CNT_W)) u_blue (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload),
    .dec    (dec_blue),
    .count  (blue_left),
    .empty  (blue_empty)
  );

  marble_stock #(.INIT(RED_COUNT), .CNT_W(CNT_W)) u_red (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload),
    .dec    (dec_red),
    .count  (red_left),
    .empty  (red_empty)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    start_d  = 1'b0;
    colour_d = colour_q;
    halt_d   = halt_q;
    log_d    = log_q;
    len_d    = len_q;
    settle_d = settle_q;
    reload   = 1'b0;
    rel      = 1'b0;
    dec_blue = 1'b0;
    dec_red  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          reload = 1'b1;
          log_d  = '0;
          len_d  = '0;
          halt_d = HALT_NONE;
          sel_d  = go_colour;
          // Stocks are being reloaded, so emptiness is judged on the reload value.
          if (((go_colour == BLUE) && (BLUE_COUNT == 0)) ||
              ((go_colour == RED)  && (RED_COUNT  == 0))) begin
            state_d = S_DONE;
            halt_d  = HALT_EMPTY;
          end else begin
            rel = 1'b1;
          end
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        if (stopped) begin
          state_d = S_DONE;
          halt_d  = HALT_INTERCEPT;
        end else if (lever_hit) begin
          log_d = {log_q[LOG_DEPTH-2:0], lever_side};
          if (len_q != LEN_MAX) len_d = len_q + 1'b1;
          sel_d = lever_side;
          if ((lever_side == RED) ? red_empty : blue_empty) begin
            state_d = S_DONE;
            halt_d  = HALT_EMPTY;
          end else if (SETTLE == 0) begin
            rel = 1'b1;
          end else begin
            settle_d = SETTLE_LOAD;
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) rel = 1'b1;
        else                settle_d = settle_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering RELEASE: pulse start, latch colour and take the marble from stock on the same edge.
    if (rel) begin
      state_d  = S_RELEASE;
      start_d  = 1'b1;
      colour_d = sel_d;
      dec_blue = (sel_d == BLUE);
      dec_red  = (sel_d == RED);
    end

    busy_d = (state_d == S_RELEASE) || (state_d == S_RUN) || (state_d == S_SETTLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= BLUE;
      start_q  <= 1'b0;
      colour_q <= BLUE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      halt_q   <= HALT_NONE;
      log_q    <= '0;
      len_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      halt_q   <= halt_d;
      log_q    <= log_d;
      len_q    <= len_d;
      settle_q <= settle_d;
    end
  end

  assign start         = start_q;
  assign marble_colour = colour_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign halt_reason   = halt_q;
  assign log           = log_q;
  assign log_len       = len_q;

endmodule

// File: tb/tb_marble_launcher.sv
// Bench for marble_launcher: event-timed reference model checked every cycle, plus directed literal checks.
module tb_marble_launcher;

  localparam int BC  = 12;
  localparam int RC  = 12;
  localparam int CW  = 4;
  localparam int ST  = 2;
  localparam int LD  = 16;
  localparam int LW  = $clog2(LD + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0, go_colour = 1'b0, lever_hit = 1'b0, lever_side = 1'b0, stopped = 1'b0;
  logic          start, marble_colour, busy, done;
  logic [CW-1:0] blue_left, red_left;
  logic [1:0]    halt_reason;
  logic [LD-1:0] log;
  logic [LW-1:0] log_len;

  marble_launcher #(
    .BLUE_COUNT(BC), .RED_COUNT(RC), .CNT_W(CW), .SETTLE(ST), .LOG_DEPTH(LD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .go_colour(go_colour),
    .lever_hit(lever_hit), .lever_side(lever_side), .stopped(stopped),
    .start(start), .marble_colour(marble_colour), .blue_left(blue_left),
    .red_left(red_left), .busy(busy), .done(done), .halt_reason(halt_reason),
    .log(log), .log_len(log_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy, 2 done; releases are scheduled by edge number.
  int     m_phase = 0;
  bit     m_pend = 0;
  longint m_edge = 0, m_rel = 0, m_run_from = 0;
  int     m_blue = BC, m_red = RC, m_halt = 0;
  bit     m_c = 0, m_colour = 0, m_start = 0;
  bit     m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pend = 0; m_blue = BC; m_red = RC; m_halt = 0;
      m_c = 0; m_colour = 0; m_start = 0; m_q.delete();
    end else begin
      m_edge++;
      m_start = 0;
      if (m_phase != 1) begin
        if (go) begin
          m_blue = BC; m_red = RC; m_q.delete(); m_halt = 0; m_c = go_colour;
          if ((m_c ? m_red : m_blue) == 0) begin
            m_phase = 2; m_halt = 2;
          end else begin
            m_phase = 1; m_pend = 1; m_rel = m_edge;
          end
        end
      end else if (!m_pend && m_edge >= m_run_from) begin
        if (stopped) begin
          m_phase = 2; m_halt = 1;
        end else if (lever_hit) begin
          m_q.push_front(lever_side);
          if (m_q.size() > LD) void'(m_q.pop_back());
          m_c = lever_side;
          if ((m_c ? m_red : m_blue) == 0) begin
            m_phase = 2; m_halt = 2;
          end else begin
            m_pend = 1; m_rel = m_edge + ST;
          end
        end
      end
      if (m_phase == 1 && m_pend && m_edge == m_rel) begin
        m_pend = 0; m_start = 1; m_colour = m_c;
        if (m_c) m_red--; else m_blue--;
        m_run_from = m_edge + 2;
      end
    end
  end

  always @(negedge clk) begin
    logic [LD-1:0] lv;
    lv = '0;
    for (int i = 0; i < m_q.size(); i++) lv[i] = m_q[i];
    chk("start", start, m_start);
    chk("marble_colour", marble_colour, m_colour);
    chk("blue_left", blue_left, m_blue);
    chk("red_left", red_left, m_red);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("halt_reason", halt_reason, m_halt);
    chk("log", log, lv);
    chk("log_len", log_len, m_q.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("lit_reset_start", start, 0);
    chk("lit_reset_blue", blue_left, 12);
    chk("lit_reset_red", red_left, 12);
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_halt", halt_reason, 0);
    chk("lit_reset_log_len", log_len, 0);

    // first release: start in the cycle right after go is sampled
    go = 1; go_colour = 0; tick(); go = 0;
    chk("lit_go_start", start, 1);
    chk("lit_go_colour", marble_colour, 0);
    chk("lit_go_blue", blue_left, 11);
    chk("lit_go_busy", busy, 1);
    tick();
    chk("lit_go_start_drop", start, 0);

    // red lever hit: start comes SETTLE+1 cycles later
    lever_hit = 1; lever_side = 1; tick(); lever_hit = 0;
    chk("lit_hit_start0", start, 0);
    chk("lit_hit_log_len", log_len, 1);
    chk("lit_hit_log", log, 16'h0001);
    tick();
    chk("lit_hit_start1", start, 0);
    tick();
    chk("lit_hit_start2", start, 1);
    chk("lit_hit_colour", marble_colour, 1);
    chk("lit_hit_red", red_left, 11);
    tick();

    // stop and hit together: stop wins, hit not logged
    stopped = 1; lever_hit = 1; lever_side = 0; tick(); stopped = 0; lever_hit = 0;
    chk("lit_stop_done", done, 1);
    chk("lit_stop_halt", halt_reason, 1);
    chk("lit_stop_log_len", log_len, 1);
    chk("lit_stop_log", log, 16'h0001);
    repeat (3) tick();
    chk("lit_stop_no_start", start, 0);

    // 20 alternating hits overflow the 16-entry log
    go = 1; go_colour = 0; tick(); go = 0; tick();
    for (int k = 0; k < 20; k++) begin
      lever_hit = 1; lever_side = (k % 2 == 0); tick(); lever_hit = 0;
      repeat (3) tick();
    end
    chk("lit_ovf_log_len", log_len, 16);
    chk("lit_ovf_log", log, 16'hAAAA);
    chk("lit_ovf_blue", blue_left, 1);
    chk("lit_ovf_red", red_left, 2);
    stopped = 1; tick(); stopped = 0;
    chk("lit_ovf_halt", halt_reason, 1);

    // drain blue until the empty hit ends the run
    go = 1; go_colour = 0; tick(); go = 0; tick();
    for (int k = 0; k < 12; k++) begin
      lever_hit = 1; lever_side = 0; tick(); lever_hit = 0;
      repeat (3) tick();
    end
    chk("lit_empty_done", done, 1);
    chk("lit_empty_halt", halt_reason, 2);
    chk("lit_empty_blue", blue_left, 0);
    chk("lit_empty_busy", busy, 0);
    chk("lit_empty_log_len", log_len, 12);

    // reset in SETTLE drops the pending release
    go = 1; go_colour = 1; tick(); go = 0; tick();
    lever_hit = 1; lever_side = 0; tick(); lever_hit = 0;
    rst_n = 0; tick(); rst_n = 1;
    chk("lit_rst_start", start, 0);
    chk("lit_rst_blue", blue_left, 12);
    chk("lit_rst_red", red_left, 12);
    chk("lit_rst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lit_rst_no_start", start, 0);
    end
    go = 1; go_colour = 0; tick(); go = 0;
    chk("lit_rst_go_start", start, 1);
    chk("lit_rst_go_blue", blue_left, 11);

    // randomized traffic, including go during busy and occasional resets
    for (int k = 0; k < 4000; k++) begin
      go         = ($urandom_range(0, 19) == 0);
      go_colour  = $urandom_range(0, 1);
      lever_hit  = ($urandom_range(0, 2) == 0);
      lever_side = $urandom_range(0, 1);
      stopped    = ($urandom_range(0, 39) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      tick();
    end
    go = 0; lever_hit = 0; stopped = 0; rst_n = 1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/marble_launcher.md
Name: marble_launcher

Overview:
- Marble release mechanism that drives a `puzzle` board, with the board's outputs fed back into it.
- Holds a blue stock and a red stock of marbles and releases one marble per `start` pulse, tagged with its colour.
- When the board reports a lever hit, the launcher releases the next marble of that lever's side.
- The run ends when the board halts (interceptor) or the requested colour is empty. It keeps a log of lever sides for pattern checking.

Parameters:
- BLUE_COUNT, 8, blue marbles loaded at reset/reload.
- RED_COUNT, 8, red marbles loaded at reset/reload.
- CNT_W, 4, stock counter width; BLUE_COUNT and RED_COUNT must be at most 2^CNT_W-1.
- SETTLE, 2, idle cycles between an accepted lever hit and the next release (0 is legal).
- LOG_DEPTH, 16, number of lever-side entries retained in the log.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle request to start a run.
- go_colour  in  1  colour of the first marble (0 = blue, 1 = red).
- lever_hit  in  1  one-cycle pulse: marble reached a lever.
- lever_side  in  1  lever hit (0 = blue/left, 1 = red/right); valid with lever_hit.
- stopped  in  1  board halted the marble (interceptor).
- start  out  1  one-cycle release pulse to the puzzle.
- marble_colour  out  1  colour of the last released marble; updates with start.
- blue_left  out  CNT_W  remaining blue stock.
- red_left  out  CNT_W  remaining red stock.
- busy  out  1  high in RELEASE, RUN and SETTLE.
- done  out  1  high in DONE.
- halt_reason  out  2  00 none, 01 intercepted, 10 out of marbles, 11 reserved.
- log  out  LOG_DEPTH  lever-side history; bit 0 is the newest.
- log_len  out  $clog2(LOG_DEPTH+1)  valid entries, saturating.

Behaviour:
- Reset values:
  - start=0, marble_colour=0, busy=0, done=0, halt_reason=00, log=0, log_len=0.
  - blue_left=BLUE_COUNT, red_left=RED_COUNT.
  - FSM in IDLE.
- FSM states: IDLE, RELEASE, RUN, SETTLE, DONE. All outputs are registered.
- IDLE or DONE, go=1:
  - Reload both stocks, clear log/log_len, clear halt_reason.
  - Select colour c=go_colour.
  - If stock[c] at its reload value is 0: go to DONE with halt_reason=10. No start is issued.
  - Otherwise: go to RELEASE.
- RELEASE (exactly one cycle):
  - start=1, marble_colour=c, stock[c] decrements on the same edge.
  - Then go to RUN.
- Latency: go sampled at edge n gives start high during cycle n+1.
- RUN:
  - stopped=1: go to DONE, halt_reason=01. stopped has priority over a simultaneous lever_hit, and that lever_hit is not logged.
  - lever_hit=1: shift lever_side into log bit 0, log_len += 1 (saturating at LOG_DEPTH), set c=lever_side.
    - If stock[c]==0: go to DONE with halt_reason=10.
    - Else if SETTLE==0: go to RELEASE.
    - Else: load the settle counter with SETTLE-1 and go to SETTLE.
- SETTLE: count down to 0, then go to RELEASE.
- Release latency after a lever hit: start is asserted exactly SETTLE+1 cycles after the edge that sampled lever_hit.
- Ignored inputs:
  - lever_hit and stopped are ignored outside RUN (no log change).
  - go is ignored in RELEASE, RUN and SETTLE.
- Stock counters never wrap below 0. Decrement happens only in RELEASE, and RELEASE is entered only with nonzero stock.
- Log overflow: the oldest bit shifts out and log_len stays at LOG_DEPTH.
- Reset asserted mid-run: immediate return to reset values. Any start in flight is dropped asynchronously.
- DONE holds all outputs until go or reset.

Decomposition:
- Package tt_pkg:
  - colour constants BLUE=1'b0, RED=1'b1;
  - halt codes HALT_NONE/HALT_INTERCEPT/HALT_EMPTY;
  - FSM state encoding.
- Sub-module marble_stock (parameters INIT, CNT_W), instantiated once per colour:
  - inputs: reload, dec;
  - outputs: count, empty.
- FSM, settle counter and log live in marble_launcher.

Test Plan:
- Reset then go (go_colour=0) at cycle 10 -> start=1 only in cycle 11, marble_colour=0, blue_left=7, red_left=8, busy=1.
- In RUN, lever_hit with lever_side=1, SETTLE=2, hit sampled at edge 20 -> start at cycle 23, marble_colour=1, red_left=7, log=…01, log_len=1.
- stopped and lever_hit together in RUN -> done=1, halt_reason=01, log unchanged, no further start.
- BLUE_COUNT=2: go blue, then two lever_hit side 0 -> starts for 2 marbles, on the second hit blue_left=0, done=1, halt_reason=10.
- 20 accepted lever hits with alternating sides, LOG_DEPTH=16 -> log_len=16, log=16'h5555 or 16'hAAAA as per last side.
- rst_n low for 1 cycle during SETTLE -> no start afterward, stocks=8/8, busy=0; go after release works normally.
